// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract that reuses one N-bit ripple-carry adder, one word per cycle, LSW first.
// Result is valid WORDS cycles after accept and is held until out_ready; requests are never queued.
module multiword_add_sequencer #(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WORDS-1:0] a,
   input  logic [N*WORDS-1:0] b,
   input  logic               sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*WORDS-1:0] sum,
   output logic               c_out
);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N*WORDS-1:0] r_a;
   logic [N*WORDS-1:0] r_b;
   logic [N*WORDS-1:0] r_sum;
   logic               r_sub;
   logic               r_carry;
   logic               r_cout;
   logic [IW-1:0]      r_idx;

   logic [N-1:0]       w_op_a;
   logic [N-1:0]       w_op_b;
   logic [N-1:0]       w_add_sum;
   logic [N:0]         w_rc;
   logic               w_accept;
   logic               w_last;

   // The single shared adder: subtraction feeds ~b with the carry register seeded to 1.
   always_comb begin
      w_op_a = r_a[int'(r_idx)*N +: N];
      w_op_b = r_sub ? ~r_b[int'(r_idx)*N +: N] : r_b[int'(r_idx)*N +: N];
      w_add_sum = '0;
      w_rc = '0;
      w_rc[0] = r_carry;
      for (int i = 0; i < N; i++) begin
         w_add_sum[i] = w_op_a[i] ^ w_op_b[i] ^ w_rc[i];
         w_rc[i+1]    = (w_op_a[i] & w_op_b[i]) | (w_rc[i] & (w_op_a[i] ^ w_op_b[i]));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      w_last      = (r_idx == LAST);
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            w_accept = in_valid;
            if (in_valid) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // The index parks on the last word rather than wrapping; the next accept clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_sub   <= sub;
         r_carry <= sub;
         r_idx   <= '0;
      end else if (r_state == RUN) begin
         r_sum[int'(r_idx)*N +: N] <= w_add_sum;
         r_carry <= w_rc[N];
         if (w_last) begin
            r_cout <= w_rc[N];
         end else begin
            r_idx <= r_idx + IW'(1);
         end
      end
   end

   assign sum   = r_sum;
   assign c_out = r_cout;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer (N=8, WORDS=4): directed corners, backpressure, reset, random traffic.
module tb_multiword_add_sequencer;
   localparam int N     = 8;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out)
   );

   // Reference: plain wide arithmetic; result is {carry/no-borrow, value}.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      if (s) return {(x >= y), x - y};
      return {1'b0, x} + {1'b0, y};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0; in_valid = 1'b0;
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      vectors++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
      vectors++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b expected 0", c_out); end
      tick();
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_no_accept: in_ready got %b expected 1", in_ready); end
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [4] = '{32'h000000FF, 32'hFFFFFFFF, 32'h00000005, 32'h00000007};
      logic [W-1:0] tb [4] = '{32'h00000001, 32'h00000001, 32'h00000007, 32'h00000005};
      logic         ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] es [4] = '{32'h00000100, 32'h00000000, 32'hFFFFFFFE, 32'h00000002};
      logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int lat;
      for (int k = 0; k < 4; k++) begin
         a = ta[k]; b = tb[k]; sub = ts[k]; in_valid = 1'b1; out_ready = 1'b1;
         vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_ready: got %b expected 1", k, in_ready); end
         tick();
         in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
         vectors++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 4", k, lat); end
         vectors++; if (sum !== es[k]) begin errors++; $display("FAIL dir%0d_sum: got %h expected %h", k, sum, es[k]); end
         vectors++; if (c_out !== ec[k]) begin errors++; $display("FAIL dir%0d_c_out: got %b expected %b", k, c_out, ec[k]); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a1, b1, a2, b2;
      logic         s1, s2;
      logic [W:0]   e1, e2;
      int lat;
      a1 = $urandom; b1 = $urandom; s1 = 1'b1; e1 = model(a1, b1, s1);
      a2 = $urandom; b2 = $urandom; s2 = 1'b0; e2 = model(a2, b2, s2);
      a = a1; b = b1; sub = s1; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
      vectors++; if (lat != 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", lat); end
      for (int k = 0; k < 10; k++) begin
         a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
         tick();
         vectors++;
         if (sum !== e1[W-1:0] || c_out !== e1[W] || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: got sum=%h c=%b ov=%b ir=%b expected sum=%h c=%b ov=1 ir=0",
                     k, sum, c_out, out_valid, in_ready, e1[W-1:0], e1[W]);
         end
      end
      a = a2; b = b2; sub = s2; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid); end
      vectors++; if (sum !== e1[W-1:0]) begin errors++; $display("FAIL bp_sum_kept: got %h expected %h", sum, e1[W-1:0]); end
      tick();
      in_valid = 1'b0;
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: in_ready got %b expected 0", in_ready); end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
      vectors++; if (lat != 4) begin errors++; $display("FAIL bp2_latency: got %0d expected 4", lat); end
      vectors++; if (sum !== e2[W-1:0] || c_out !== e2[W]) begin errors++; $display("FAIL bp2_result: got %h/%b expected %h/%b", sum, c_out, e2[W-1:0], e2[W]); end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int seen;
      a = 32'h12345678; b = 32'h11111111; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (sum !== '0 || c_out !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrun_reset: got sum=%h c=%b ov=%b ir=%b expected 0/0/0/1", sum, c_out, out_valid, in_ready);
      end
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (out_valid !== 1'b0) seen++;
      end
      vectors++; if (seen != 0) begin errors++; $display("FAIL midrun_no_result: got %0d valid cycles expected 0", seen); end
   endtask

   task automatic test_back_to_back_random();
      logic [W-1:0] ra, rb;
      logic         rs, hs;
      logic [W:0]   e;
      int lat, guard;
      for (int n = 0; n < 1000; n++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: rb = ra;
            1: ra = '0;
            2: ra = '1;
            default: ;
         endcase
         e = model(ra, rb, rs);
         a = ra; b = rb; sub = rs; in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1));
         vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready: got %b expected 1", n, in_ready); end
         tick();
         in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
         end
         vectors++; if (lat != 4) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 4", n, lat); end
         vectors++; if (sum !== e[W-1:0]) begin errors++; $display("FAIL rnd%0d_sum: a=%h b=%h sub=%b got %h expected %h", n, ra, rb, rs, sum, e[W-1:0]); end
         vectors++; if (c_out !== e[W]) begin errors++; $display("FAIL rnd%0d_c_out: got %b expected %b", n, c_out, e[W]); end
         guard = 0;
         do begin
            out_ready = (guard >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
            hs = out_ready;
            in_valid = 1'($urandom_range(0, 1));
            tick();
            guard++;
         end while (!hs);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
